// File: rtl/hazard_annunciator.sv
// Hazard annunciator: debounces the red/yellow/green hazard class, latches red alarms until
// acknowledged, blinks indicators for unacknowledged alarm and fault, and counts alarm entries.
module hazard_annunciator #(
    parameter int QUAL_CYCLES = 4,
    parameter int BLINK_HALF  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Ired,
    input  logic       Iyellow,
    input  logic       Igreen,
    input  logic       Iack,
    output logic       Oled_red,
    output logic       Oled_yellow,
    output logic       Oled_green,
    output logic       Obuzzer,
    output logic [2:0] Ostate,
    output logic [7:0] Oalarm_cnt
);

    localparam int QW = $clog2(QUAL_CYCLES + 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QUAL_CYCLES);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        SAFE    = 3'd0,
        CAUTION = 3'd1,
        ALARM   = 3'd2,
        ACKED   = 3'd3,
        FAULT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        C_NONE   = 2'd0,
        C_GREEN  = 2'd1,
        C_YELLOW = 2'd2,
        C_RED    = 2'd3
    } cls_t;

    state_t          state_q, state_n;
    cls_t            cls, cand_q;
    logic [QW-1:0]   qcnt_q, qcnt_n;
    logic            fire;
    logic [BW-1:0]   bcnt_q, bcnt_n;
    logic            phase_q, phase_n;
    logic            entering_blink;

    // Highest-priority level wins when several are asserted.
    always_comb begin
        if (Ired)         cls = C_RED;
        else if (Iyellow) cls = C_YELLOW;
        else if (Igreen)  cls = C_GREEN;
        else              cls = C_NONE;
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        qcnt_n = qcnt_q;
        if (cls != cand_q)       qcnt_n = QW'(1);
        else if (qcnt_q < QMAX)  qcnt_n = qcnt_q + QW'(1);
        // One event per stable run: only on the edge where the count reaches the target.
        fire = (qcnt_n == QMAX) && ((cls != cand_q) || (qcnt_q != QMAX));
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            SAFE: if (fire) begin
                if (cls == C_RED)         state_n = ALARM;
                else if (cls == C_YELLOW) state_n = CAUTION;
                else if (cls == C_NONE)   state_n = FAULT;
            end
            CAUTION: if (fire) begin
                if (cls == C_RED)        state_n = ALARM;
                else if (cls == C_GREEN) state_n = SAFE;
                else if (cls == C_NONE)  state_n = FAULT;
            end
            FAULT: if (fire) begin
                if (cls == C_RED)         state_n = ALARM;
                else if (cls == C_YELLOW) state_n = CAUTION;
                else if (cls == C_GREEN)  state_n = SAFE;
            end
            ALARM: if (Iack) state_n = ACKED;
            ACKED: if (fire) begin
                if (cls == C_GREEN)       state_n = SAFE;
                else if (cls == C_YELLOW) state_n = CAUTION;
                else if (cls == C_NONE)   state_n = FAULT;
            end
            default: state_n = SAFE;
        endcase
    end

    // Restart the blink on entry so the first lit half is a full period.
    always_comb begin
        entering_blink = (state_n != state_q) && ((state_n == ALARM) || (state_n == FAULT));
        bcnt_n  = bcnt_q + BW'(1);
        phase_n = phase_q;
        if (entering_blink) begin
            bcnt_n  = '0;
            phase_n = 1'b1;
        end else if (bcnt_q == BMAX) begin
            bcnt_n  = '0;
            phase_n = ~phase_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SAFE;
            cand_q      <= C_NONE;
            qcnt_q      <= '0;
            bcnt_q      <= '0;
            phase_q     <= 1'b1;
            Oalarm_cnt  <= 8'd0;
            Oled_red    <= 1'b0;
            Oled_yellow <= 1'b0;
            Oled_green  <= 1'b0;
            Obuzzer     <= 1'b0;
        end else begin
            state_q <= state_n;
            cand_q  <= cls;
            qcnt_q  <= qcnt_n;
            bcnt_q  <= bcnt_n;
            phase_q <= phase_n;
            if ((state_n == ALARM) && (state_q != ALARM) && (Oalarm_cnt != 8'hFF))
                Oalarm_cnt <= Oalarm_cnt + 8'd1;
            Oled_red    <= ((state_n == ALARM) && phase_n) || (state_n == ACKED);
            Oled_yellow <= (state_n == CAUTION) || ((state_n == FAULT) && phase_n);
            Oled_green  <= (state_n == SAFE);
            Obuzzer     <= (state_n == ALARM);
        end
    end

    assign Ostate = state_q;

endmodule

// File: tb/tb_hazard_annunciator.sv
// Self-checking bench for hazard_annunciator: directed scenarios plus random class runs,
// compared every edge against a run-length / elapsed-time reference model.
module tb_hazard_annunciator;

    localparam int Q  = 4;
    localparam int BH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Ired = 1'b0, Iyellow = 1'b0, Igreen = 1'b0, Iack = 1'b0;
    logic       Oled_red, Oled_yellow, Oled_green, Obuzzer;
    logic [2:0] Ostate;
    logic [7:0] Oalarm_cnt;

    hazard_annunciator #(.QUAL_CYCLES(Q), .BLINK_HALF(BH)) dut (
        .clk(clk), .rst_n(rst_n),
        .Ired(Ired), .Iyellow(Iyellow), .Igreen(Igreen), .Iack(Iack),
        .Oled_red(Oled_red), .Oled_yellow(Oled_yellow), .Oled_green(Oled_green),
        .Obuzzer(Obuzzer), .Ostate(Ostate), .Oalarm_cnt(Oalarm_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode numbers are the published state values; classes 0=none 1=green 2=yellow 3=red.
    int m_mode, m_last, m_run, m_k, m_cnt;
    bit m_fresh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input logic r, input logic y, input logic g);
        if (r) return 3;
        if (y) return 2;
        if (g) return 1;
        return 0;
    endfunction

    function automatic int next_mode(input int m, input bit ev, input int c, input bit ack);
        if (m == 2) return ack ? 3 : 2;
        if (!ev) return m;
        if (c == 3) return (m == 3) ? 3 : 2;
        case (m)
            0: return (c == 2) ? 1 : (c == 0) ? 4 : 0;
            1: return (c == 1) ? 0 : (c == 0) ? 4 : 1;
            4: return (c == 1) ? 0 : (c == 2) ? 1 : 4;
            3: return (c == 1) ? 0 : (c == 2) ? 1 : (c == 0) ? 4 : 3;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_last = 0; m_run = 0; m_k = 0; m_cnt = 0; m_fresh = 1'b1;
    endtask

    task automatic model_edge();
        int c, nm;
        bit ev;
        c = cls_of(Ired, Iyellow, Igreen);
        if (m_run == 0 || c != m_last) begin
            m_last = c;
            m_run  = 1;
        end else begin
            m_run++;
        end
        ev = (m_run == Q);
        nm = next_mode(m_mode, ev, c, Iack);
        if (nm != m_mode && (nm == 2 || nm == 4)) m_k = 0;
        else m_k++;
        if (nm == 2 && m_mode != 2 && m_cnt < 255) m_cnt++;
        m_mode  = nm;
        m_fresh = 1'b0;
    endtask

    task automatic check_all(input string tag);
        bit lit, er, ey, eg, eb;
        lit = ((m_k / BH) % 2) == 0;
        eg  = !m_fresh && (m_mode == 0);
        ey  = !m_fresh && ((m_mode == 1) || (m_mode == 4 && lit));
        er  = !m_fresh && ((m_mode == 3) || (m_mode == 2 && lit));
        eb  = !m_fresh && (m_mode == 2);
        check({tag, ".state"},  32'(Ostate),      32'(m_mode));
        check({tag, ".red"},    32'(Oled_red),    32'(er));
        check({tag, ".yellow"}, 32'(Oled_yellow), 32'(ey));
        check({tag, ".green"},  32'(Oled_green),  32'(eg));
        check({tag, ".buzzer"}, 32'(Obuzzer),     32'(eb));
        check({tag, ".cnt"},    32'(Oalarm_cnt),  32'(m_cnt));
    endtask

    task automatic step(input string tag, input logic r, input logic y, input logic g, input logic a);
        Ired = r; Iyellow = y; Igreen = g; Iack = a;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic hold(input string tag, input int n, input logic r, input logic y, input logic g);
        for (int i = 0; i < n; i++) step(tag, r, y, g, 1'b0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all(tag);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12 check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        step("first_edge", 1'b0, 1'b0, 1'b1, 1'b0);

        // Short yellow run is rejected, full run reaches CAUTION.
        hold("yellow3", 3, 1'b0, 1'b1, 1'b0);
        hold("green_settle", 5, 1'b0, 1'b0, 1'b1);
        hold("yellow4", 4, 1'b0, 1'b1, 1'b0);

        // Alarm, full blink cycle, ack, back to safe.
        hold("red4", 4, 1'b1, 1'b0, 1'b0);
        hold("alarm_blink", 20, 1'b1, 1'b0, 1'b0);
        step("ack", 1'b1, 1'b0, 1'b0, 1'b1);
        hold("acked_hold", 3, 1'b1, 1'b0, 1'b0);
        hold("green_clear", 4, 1'b0, 1'b0, 1'b1);

        // Latched alarm ignores green; ack in SAFE is ignored.
        hold("red_again", 4, 1'b1, 1'b0, 1'b0);
        hold("alarm_latched", 20, 1'b0, 1'b0, 1'b1);
        step("ack2", 1'b0, 1'b0, 1'b1, 1'b1);
        hold("green_safe", 4, 1'b0, 1'b0, 1'b1);
        step("ack_in_safe", 1'b0, 1'b0, 1'b1, 1'b1);
        hold("safe_after_ack", 2, 1'b0, 1'b0, 1'b1);

        // Fault blink, then priority resolution of all levels.
        hold("none_fault", 4, 1'b0, 1'b0, 1'b0);
        hold("fault_blink", 20, 1'b0, 1'b0, 1'b0);
        hold("all_levels", 4, 1'b1, 1'b1, 1'b1);
        hold("all_alarm", 3, 1'b1, 1'b1, 1'b1);

        // Reset mid-alarm clears outputs without a clock.
        pulse_reset("reset_mid_alarm");
        step("post_reset_edge", 1'b0, 1'b0, 1'b1, 1'b0);

        // Red qualify coincident with ack from CAUTION goes to ALARM.
        hold("to_caution", 4, 1'b0, 1'b1, 1'b0);
        hold("red_pre", 3, 1'b1, 1'b0, 1'b0);
        step("red_with_ack", 1'b1, 1'b0, 1'b0, 1'b1);
        step("ack_clear", 1'b1, 1'b0, 1'b0, 1'b1);
        hold("green_back", 4, 1'b0, 1'b0, 1'b1);

        // Counter saturation.
        for (int i = 0; i < 260; i++) begin
            hold("sat_red", 4, 1'b1, 1'b0, 1'b0);
            step("sat_ack", 1'b1, 1'b0, 1'b0, 1'b1);
            hold("sat_green", 4, 1'b0, 1'b0, 1'b1);
        end
        check("sat_final", 32'(Oalarm_cnt), 32'd255);

        // Random class runs with occasional acknowledge.
        pulse_reset("reset_random");
        for (int n = 0; n < 300; n++) begin
            logic r, y, g;
            int len;
            r = 1'($urandom_range(0, 3) == 0);
            y = 1'($urandom);
            g = 1'($urandom);
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++)
                step("rand", r, y, g, 1'($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
